// File: rtl/tt_fpga_io_pkg.sv
// Shared defaults and helpers for the TT FPGA I/O bank.
package tt_fpga_io_pkg;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FILT_LIMIT  = 4;

   // Width of a counter that must hold values 0..limit.
   function automatic int cnt_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/tt_fpga_pin_filter.sv
// One pin: input synchroniser, consecutive-mismatch glitch filter and edge pulses.
module tt_fpga_pin_filter
   import tt_fpga_io_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_LIMIT  = DEF_FILT_LIMIT
) (
   input  logic clk,
   input  logic rst,
   input  logic pad_in,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int            CW   = cnt_width(FILT_LIMIT);
   localparam logic [CW-1:0] LAST = CW'(FILT_LIMIT - 1);

   logic [SYNC_STAGES-1:0] chain;
   logic                   sync;
   logic [CW-1:0]          cnt;
   logic                   accept;

   assign sync   = chain[SYNC_STAGES-1];
   // The counter never exceeds LAST, so it can never wrap.
   assign accept = (sync != stable) && (cnt == LAST);

   // Metastability chain; the asynchronous pad enters at bit 0.
   always_ff @(posedge clk) begin
      if (rst) chain <= '0;
      else     chain <= {chain[SYNC_STAGES-2:0], pad_in};
   end

   // Accept a new level only after FILT_LIMIT consecutive mismatching cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable <= 1'b0;
         cnt    <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= accept &  sync;
         fall <= accept & ~sync;
         if (sync == stable) begin
            cnt <= '0;
         end else if (accept) begin
            stable <= sync;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/tt_fpga_io_bank.sv
// Bank of WIDTH bidirectional pins: filtered inputs with edge pulses, registered outputs.
module tt_fpga_io_bank
   import tt_fpga_io_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_LIMIT  = DEF_FILT_LIMIT,
   parameter bit LOOPBACK    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pad_in,
   output logic [WIDTH-1:0] pad_out,
   output logic [WIDTH-1:0] pad_oe,
   input  logic [WIDTH-1:0] core_out,
   input  logic [WIDTH-1:0] core_oe,
   output logic [WIDTH-1:0] core_in,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [WIDTH-1:0] stable;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      tt_fpga_pin_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_LIMIT  (FILT_LIMIT)
      ) u_pin (
         .clk    (clk),
         .rst    (rst),
         .pad_in (pad_in[i]),
         .stable (stable[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

   // Register drive values and enables; reset leaves every pad undriven.
   always_ff @(posedge clk) begin
      if (rst) begin
         pad_out <= '0;
         pad_oe  <= '0;
      end else begin
         pad_out <= core_out;
         pad_oe  <= core_oe;
      end
   end

   // In loopback, driven pins report what they drive; edges still come from the filter.
   assign core_in = LOOPBACK ? ((pad_oe & pad_out) | (~pad_oe & stable)) : stable;

endmodule

// File: tb/tb_tt_fpga_io_bank.sv
// Self-checking bench: scenario tasks plus randomized traffic against a window-based model.
module tb_tt_fpga_io_bank;

   localparam int W = 8;
   localparam int S = 2;
   localparam int F = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [W-1:0] pad_in, core_out, core_oe;
   logic [W-1:0] pad_out0, pad_oe0, core_in0, rise0, fall0;
   logic [W-1:0] pad_out1, pad_oe1, core_in1, rise1, fall1;

   int total = 0;
   int bad   = 0;

   tt_fpga_io_bank #(.WIDTH(W), .SYNC_STAGES(S), .FILT_LIMIT(F), .LOOPBACK(1'b0)) dut0 (
      .clk(clk), .rst(rst), .pad_in(pad_in), .pad_out(pad_out0), .pad_oe(pad_oe0),
      .core_out(core_out), .core_oe(core_oe), .core_in(core_in0), .rise(rise0), .fall(fall0));

   tt_fpga_io_bank #(.WIDTH(W), .SYNC_STAGES(S), .FILT_LIMIT(F), .LOOPBACK(1'b1)) dut1 (
      .clk(clk), .rst(rst), .pad_in(pad_in), .pad_out(pad_out1), .pad_oe(pad_oe1),
      .core_out(core_out), .core_oe(core_oe), .core_in(core_in1), .rise(rise1), .fall(fall1));

   // Reference model: hist[j] is the pad level sampled j edges ago (zeroed by reset).
   // A pin flips when every level the filter saw over the last F cycles differs from it.
   logic [W-1:0] hist [S+F];
   logic [W-1:0] m_stable, m_rise, m_fall, m_pout, m_poe;
   logic [W-1:0] m_mis, m_nxt;

   always @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < S + F; j++) hist[j] <= '0;
         m_stable <= '0; m_rise <= '0; m_fall <= '0; m_pout <= '0; m_poe <= '0;
      end else begin
         m_mis = '1;
         for (int j = S - 1; j <= S + F - 2; j++) m_mis = m_mis & (hist[j] ^ m_stable);
         m_nxt = m_stable ^ m_mis;
         for (int j = S + F - 1; j > 0; j--) hist[j] <= hist[j-1];
         hist[0]  <= pad_in;
         m_rise   <= m_nxt & ~m_stable;
         m_fall   <= ~m_nxt & m_stable;
         m_stable <= m_nxt;
         m_pout   <= core_out;
         m_poe    <= core_oe;
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; pad_in = '1; core_oe = '1; core_out = '1;
      for (int c = 0; c < 4; c++) begin
         step();
         total++; if (pad_oe0 !== '0) begin bad++; $display("FAIL reset_pad_oe: got %h want 00", pad_oe0); end
         total++; if (pad_out0 !== '0) begin bad++; $display("FAIL reset_pad_out: got %h want 00", pad_out0); end
         total++; if (core_in0 !== '0) begin bad++; $display("FAIL reset_core_in: got %h want 00", core_in0); end
         total++; if (core_in1 !== '0) begin bad++; $display("FAIL reset_core_in_lb: got %h want 00", core_in1); end
         total++; if (rise0 !== '0 || fall0 !== '0) begin bad++; $display("FAIL reset_edges: got rise %h fall %h want 00", rise0, fall0); end
      end
      // Pad held high through release: normal filtered acceptance.
      rst = 1'b0; core_oe = '0; core_out = '0;
      for (int c = 1; c <= 8; c++) begin
         step();
         total++; if (rise0 !== ((c == 6) ? 8'hFF : 8'h00)) begin bad++; $display("FAIL release_rise c=%0d: got %h want %h", c, rise0, (c == 6) ? 8'hFF : 8'h00); end
         total++; if (core_in0 !== ((c >= 6) ? 8'hFF : 8'h00)) begin bad++; $display("FAIL release_core_in c=%0d: got %h want %h", c, core_in0, (c >= 6) ? 8'hFF : 8'h00); end
      end
      pad_in = '0;
      for (int c = 1; c <= 8; c++) begin
         step();
         total++; if (fall0 !== ((c == 6) ? 8'hFF : 8'h00)) begin bad++; $display("FAIL release_fall c=%0d: got %h want %h", c, fall0, (c == 6) ? 8'hFF : 8'h00); end
      end
   endtask

   task automatic test_held_edge();
      pad_in = 8'h01;
      for (int c = 1; c <= 8; c++) begin
         step();
         total++; if (rise0 !== ((c == 6) ? 8'h01 : 8'h00)) begin bad++; $display("FAIL held_rise c=%0d: got %h want %h", c, rise0, (c == 6) ? 8'h01 : 8'h00); end
         total++; if (core_in0 !== ((c >= 6) ? 8'h01 : 8'h00)) begin bad++; $display("FAIL held_core_in c=%0d: got %h want %h", c, core_in0, (c >= 6) ? 8'h01 : 8'h00); end
      end
      pad_in = 8'h00;
      for (int c = 1; c <= 8; c++) begin
         step();
         total++; if (fall0 !== m_fall) begin bad++; $display("FAIL held_fall c=%0d: got %h want %h", c, fall0, m_fall); end
      end
   endtask

   task automatic test_glitch();
      pad_in = 8'h08;
      for (int c = 1; c <= 12; c++) begin
         if (c == 4) pad_in = 8'h00;
         step();
         total++; if (rise0 !== '0 || fall0 !== '0 || core_in0 !== '0) begin
            bad++; $display("FAIL glitch3 c=%0d: got rise %h fall %h core_in %h want 00", c, rise0, fall0, core_in0);
         end
      end
      pad_in = 8'h08;
      for (int c = 1; c <= 14; c++) begin
         if (c == 5) pad_in = 8'h00;
         step();
         total++; if (rise0 !== ((c == 6) ? 8'h08 : 8'h00)) begin bad++; $display("FAIL glitch4_rise c=%0d: got %h want %h", c, rise0, (c == 6) ? 8'h08 : 8'h00); end
         total++; if (fall0 !== ((c == 10) ? 8'h08 : 8'h00)) begin bad++; $display("FAIL glitch4_fall c=%0d: got %h want %h", c, fall0, (c == 10) ? 8'h08 : 8'h00); end
      end
   endtask

   task automatic test_output();
      pad_in = '0; core_out = 8'hA5; core_oe = 8'h0F;
      #1;
      total++; if (pad_out0 !== 8'h00) begin bad++; $display("FAIL out_early: got %h want 00", pad_out0); end
      step();
      total++; if (pad_out0 !== 8'hA5) begin bad++; $display("FAIL out_pad_out: got %h want a5", pad_out0); end
      total++; if (pad_oe0 !== 8'h0F) begin bad++; $display("FAIL out_pad_oe: got %h want 0f", pad_oe0); end
      total++; if (core_in1 !== 8'h05) begin bad++; $display("FAIL out_loopback: got %h want 05", core_in1); end
      total++; if (core_in0 !== 8'h00) begin bad++; $display("FAIL out_no_loopback: got %h want 00", core_in0); end
      core_out = '0; core_oe = '0;
      step();
      total++; if (core_in1 !== 8'h00) begin bad++; $display("FAIL out_release: got %h want 00", core_in1); end
   endtask

   task automatic test_reset_mid();
      pad_in = 8'h20;
      for (int c = 0; c < 3; c++) step();
      rst = 1'b1;
      step();
      total++; if (core_in0 !== 8'h00 || rise0 !== 8'h00) begin bad++; $display("FAIL midrst_clear: got core_in %h rise %h want 00", core_in0, rise0); end
      rst = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         step();
         total++; if (rise0 !== ((c == 6) ? 8'h20 : 8'h00)) begin bad++; $display("FAIL midrst_rise c=%0d: got %h want %h", c, rise0, (c == 6) ? 8'h20 : 8'h00); end
      end
      pad_in = 8'h00;
      for (int c = 0; c < 8; c++) step();
   endtask

   task automatic test_independence();
      pad_in = 8'h81;
      for (int c = 1; c <= 8; c++) begin
         step();
         total++; if (rise0 !== ((c == 6) ? 8'h81 : 8'h00)) begin bad++; $display("FAIL indep_rise c=%0d: got %h want %h", c, rise0, (c == 6) ? 8'h81 : 8'h00); end
         total++; if (fall0 !== 8'h00) begin bad++; $display("FAIL indep_fall c=%0d: got %h want 00", c, fall0); end
      end
      pad_in = 8'h00;
      for (int c = 0; c < 8; c++) step();
   endtask

   task automatic test_random();
      logic [W-1:0] flip;
      for (int n = 0; n < 800; n++) begin
         flip = W'($urandom) & W'($urandom);
         pad_in   = pad_in ^ flip;
         core_out = W'($urandom);
         core_oe  = W'($urandom);
         rst      = ($urandom_range(0, 99) == 0);
         step();
         total++; if (core_in0 !== m_stable) begin bad++; $display("FAIL rnd_core_in n=%0d: got %h want %h", n, core_in0, m_stable); end
         total++; if (rise0 !== m_rise || rise1 !== m_rise) begin bad++; $display("FAIL rnd_rise n=%0d: got %h/%h want %h", n, rise0, rise1, m_rise); end
         total++; if (fall0 !== m_fall || fall1 !== m_fall) begin bad++; $display("FAIL rnd_fall n=%0d: got %h/%h want %h", n, fall0, fall1, m_fall); end
         total++; if (pad_out0 !== m_pout || pad_oe0 !== m_poe) begin bad++; $display("FAIL rnd_pad n=%0d: got %h/%h want %h/%h", n, pad_out0, pad_oe0, m_pout, m_poe); end
         total++; if (core_in1 !== ((m_poe & m_pout) | (~m_poe & m_stable))) begin
            bad++; $display("FAIL rnd_loopback n=%0d: got %h want %h", n, core_in1, (m_poe & m_pout) | (~m_poe & m_stable));
         end
         total++; if ((rise0 & fall0) !== '0) begin bad++; $display("FAIL rnd_both_edges n=%0d: got %h want 00", n, rise0 & fall0); end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pad_in = '0; core_out = '0; core_oe = '0;
      @(negedge clk);
      test_reset();
      test_held_edge();
      test_glitch();
      test_output();
      test_reset_mid();
      test_independence();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
